pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 pipeline. Each cycle it decides stall/bubble for the F, D, E, M and W pipeline registers: load/use, mispredicted jump, ret and exception handling. It owns a sticky halt FSM and saturating event counters for debug/performance. Stall/bubble outputs are combinational from current stage contents plus FSM state, so they take effect at the next clk edge of the stage registers.

Parameters:
CNT_W, 32, width of each event counter (saturating)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
D_icode  input  4  icode held in D register
d_srcA  input  4  decode-stage srcA (4'hF = none)
d_srcB  input  4  decode-stage srcB (4'hF = none)
E_icode  input  4  icode held in E register
E_dstM  input  4  dstM held in E register
e_Cnd  input  1  condition result from execute
M_icode  input  4  icode held in M register
m_stat  input  2  status produced by memory stage
W_stat  input  2  status held in W register
F_stall  output  1  hold fetch PC register
D_stall  output  1  hold D register
D_bubble  output  1  load nop into D register
E_bubble  output  1  load nop into E register
M_bubble  output  1  load nop into M register
W_stall  output  1  hold W register
halted  output  1  FSM in HALT
lu_cnt  output  CNT_W  load/use stall events
mp_cnt  output  CNT_W  mispredict events
ret_cnt  output  CNT_W  cycles with ret in D/E/M

Behaviour:
- Encodings: stat AOK=0, HLT=1, ADR=2, INS=3. icode MRMOVQ=5, POPQ=B, JXX=7, RET=9. Register none = F.
- Hazard terms (combinational):
  - loaduse = E_icode in {5,B} && E_dstM != F && (E_dstM == d_srcA || E_dstM == d_srcB).
  - mispred = E_icode == 7 && !e_Cnd.
  - retp = 9 in any of D_icode, E_icode, M_icode.
  - exc_m = m_stat != AOK; exc_w = W_stat != AOK.
- FSM states RUN, DRAIN, HALT; reset -> RUN.
  - RUN: exc_w -> HALT; else exc_m -> DRAIN; else stay.
  - DRAIN: exc_w -> HALT; else !exc_m -> RUN (exception squashed by earlier bubble); else stay.
  - HALT: stays until reset; inputs ignored.
- Outputs in RUN/DRAIN:
  - F_stall = loaduse || retp.
  - D_stall = loaduse.
  - D_bubble = mispred || (retp && !loaduse).
  - E_bubble = mispred || loaduse.
  - M_bubble = exc_m || exc_w || state==DRAIN.
  - W_stall = exc_w.
- Outputs in HALT: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, halted=1. halted=0 otherwise.
- D_stall and D_bubble never both 1; loaduse takes priority over ret.
- Counters, RUN/DRAIN only, +1 per cycle the term is true:
  - lu_cnt on loaduse; mp_cnt on mispred; ret_cnt on retp.
  - Saturate at all-ones; frozen in HALT.
  - Multiple terms in one cycle each increment their own counter.
- Reset: state=RUN, all counters 0. Outputs then follow the combinational rules from the current inputs. Reset mid-HALT returns to RUN in one cycle.

Test Plan:
- E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt 0->1 after the edge. Same with E_dstM=F -> no stall.
- E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; mp_cnt increments. e_Cnd=1 -> all 0.
- RET walks D->E->M over 3 cycles -> F_stall=1, D_bubble=1 each cycle; ret_cnt=3.
- Load/use with D_icode=9 -> D_stall=1, D_bubble=0, F_stall=1.
- m_stat=ADR one cycle, then W_stat=ADR -> M_bubble=1, DRAIN then HALT; halted=1, W_stall=1; counters frozen while inputs keep toggling.
- In HALT pulse reset 1 cycle -> halted=0, counters 0, outputs all 0 with idle inputs; lu_cnt preloaded near max saturates at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble decisions, sticky halt FSM
// and saturating hazard event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [1:0] ST_AOK   = 2'd0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] lu_q, lu_d;
  logic [CNT_W-1:0] mp_q, mp_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic loaduse, mispred, retp;
  logic exc_m, exc_w, is_halt;

  assign loaduse = (E_icode == I_MRMOVQ || E_icode == I_POPQ)
                && (E_dstM != R_NONE)
                && (E_dstM == d_srcA || E_dstM == d_srcB);
  assign mispred = (E_icode == I_JXX) && !e_Cnd;
  assign retp    = (D_icode == I_RET) || (E_icode == I_RET)
                || (M_icode == I_RET);
  assign exc_m   = (m_stat != ST_AOK);
  assign exc_w   = (W_stat != ST_AOK);
  assign is_halt = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (exc_w)      state_d = S_HALT;
        else if (exc_m) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (exc_w)       state_d = S_HALT;
        else if (!exc_m) state_d = S_RUN;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Loaduse wins over ret so D is never stalled and bubbled together.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    if (!is_halt) begin
      F_stall  = loaduse || retp;
      D_stall  = loaduse;
      D_bubble = mispred || (retp && !loaduse);
      E_bubble = mispred || loaduse;
      M_bubble = exc_m || exc_w || (state_q == S_DRAIN);
      W_stall  = exc_w;
    end
  end

  always_comb begin
    lu_d  = lu_q;
    mp_d  = mp_q;
    ret_d = ret_q;
    if (!is_halt) begin
      if (loaduse && !(&lu_q)) lu_d  = lu_q + 1'b1;
      if (mispred && !(&mp_q)) mp_d  = mp_q + 1'b1;
      if (retp && !(&ret_q))   ret_d = ret_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      lu_q    <= '0;
      mp_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      mp_q    <= mp_d;
      ret_q   <= ret_d;
    end
  end

  assign halted  = is_halt;
  assign lu_cnt  = lu_q;
  assign mp_cnt  = mp_q;
  assign ret_cnt = ret_q;

endmodule
